// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter sharing one fixed-point divider between NUM_REQ requesters
// Ports: req/req_dividend/req_divisor in, gnt one-hot accept pulse out;
//   rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err response handshake; busy = not IDLE;
//   div_in_* / div_out_* connect to the single divider instance.
// Optional macro DIV_SCHED_TIMEOUT_EN adds parameter TIMEOUT_CYCLES, a WAIT watchdog and the sticky timeout_flag output.
module div_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
`ifdef DIV_SCHED_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*10-1:0] req_dividend,
  input  logic [NUM_REQ*3-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [19:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 div_in_valid,
  output logic [9:0]           div_in_data_1,
  output logic [2:0]           div_in_data_2,
  input  logic                 div_out_valid,
  input  logic [19:0]          div_out_data
`ifdef DIV_SCHED_TIMEOUT_EN
  ,output logic                timeout_flag
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_id, w_sel, w_idx;
  logic [9:0] r_dividend;
  logic [2:0] r_divisor;
  logic [19:0] r_data;
  logic r_err, w_found, w_go, w_zero, w_lock, w_expire;
  logic [9:0] w_dvd [NUM_REQ];
  logic [2:0] w_dvs [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign w_dvd[i] = req_dividend[i*10 +: 10];
    assign w_dvs[i] = req_divisor[i*3 +: 3];
  end
  // first requester at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel = w_idx;
      end
    end
  end
  assign w_zero = w_dvs[w_sel] == 3'd0;
  assign w_go = w_found && !w_lock;
`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_to;
  // r_cnt counts WAIT cycles; expiry fires on the TIMEOUT_CYCLES-th one
  assign w_expire = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_lock = r_to;
  assign timeout_flag = r_to;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_to <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == S_WAIT && !div_out_valid && w_expire) r_to <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign w_lock = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_go ? (w_zero ? S_RESP : S_ISSUE) : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = div_out_valid ? S_DRAIN : (w_expire ? S_RESP : S_WAIT);
      S_DRAIN: w_next = div_out_valid ? S_DRAIN : S_RESP;
      S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    gnt = (r_state == S_IDLE && w_go) ? NUM_REQ'(1) << w_sel : '0;
    busy = r_state != S_IDLE;
    div_in_valid = r_state == S_ISSUE;
    div_in_data_1 = r_dividend;
    div_in_data_2 = r_divisor;
    rsp_valid = r_state == S_RESP;
    rsp_id = r_id;
    rsp_data = r_data;
    rsp_err = r_err;
  end
  // divide-by-zero preloads the all-ones answer; a divider result overwrites it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id <= '0;
      r_dividend <= '0;
      r_divisor <= '0;
      r_data <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_go) begin
        r_ptr <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        r_id <= w_sel;
        r_dividend <= w_dvd[w_sel];
        r_divisor <= w_dvs[w_sel];
        r_data <= '1;
        r_err <= w_zero;
      end
      if (r_state == S_WAIT && div_out_valid) begin
        r_data <= div_out_data;
        r_err <= 1'b0;
      end else if (r_state == S_WAIT && w_expire) begin
        r_data <= '0;
        r_err <= 1'b1;
      end
    end
  end
endmodule
